// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control logic: hazard FSM states, the
// bundled stage-control word, and the load-use compare.
package cpu_types_pkg;

    // Hazard controller states, kept as plain constants over a 2-bit type
    // so older code that compares raw state bits still works.
    typedef logic [1:0] hz_state_t;
    localparam hz_state_t RUN   = 2'd0;
    localparam hz_state_t DWAIT = 2'd1;
    localparam hz_state_t HALT  = 2'd2;

    // One word carrying every enable/flush the controller drives.
    typedef struct packed {
        logic pcEn;
        logic ifidEn;
        logic ifidFlush;
        logic idW;
        logic idRst;
        logic exmemEn;
        logic exmemFlush;
        logic memwbEn;
    } hzCtrl_t;

    // Free-running pipe: every stage advances, nothing squashed.
    localparam hzCtrl_t CTRL_RUN    = 8'b1101_0101;
    // Whole pipe frozen (data-memory wait, or halted).
    localparam hzCtrl_t CTRL_FREEZE = 8'b0000_0000;
    // Front end held, bubble into ID/EX, back end keeps draining.
    localparam hzCtrl_t CTRL_BUBBLE = 8'b0001_1101;
    // MEM-resolved branch: load target, squash IF/ID and ID/EX.
    localparam hzCtrl_t CTRL_BRANCH = 8'b1111_1101;
    // EX-resolved jump: load target, squash IF/ID only.
    localparam hzCtrl_t CTRL_JUMP   = 8'b1111_0101;

    // True when the load sitting in ID/EX writes a register that the
    // instruction in decode reads. r0 is never a real dependency.
    function automatic logic isLoadUse(
        input logic       exDRE,
        input logic [4:0] exrt,
        input logic [4:0] idrsel1,
        input logic [4:0] idrsel2,
        input logic       iduses2
    );
        return exDRE && (exrt != 5'd0) &&
               ((exrt == idrsel1) || (iduses2 && (exrt == idrsel2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones instead of wrapping.
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: resolves halt, data-memory
// wait, branch/jump redirects, load-use and I-fetch stalls into stage
// register enables/flushes, and keeps stall/flush performance counters.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int BR_FLUSH = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memREN,
    input  logic             memWEN,
    input  logic             exDRE,
    input  logic [4:0]       exrt,
    input  logic [4:0]       idrsel1,
    input  logic [4:0]       idrsel2,
    input  logic             iduses2,
    input  logic             brtaken,
    input  logic             jmp,
    input  logic             memHALT,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idW,
    output logic             idRST,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state;
    hz_state_t nextState;
    hzCtrl_t   ctrl;
    logic      dwait;
    logic      loadUse;
    logic      redirect;

    assign dwait   = (memREN | memWEN) & ~dhit;
    assign loadUse = isLoadUse(exDRE, exrt, idrsel1, idrsel2, iduses2);

    // Priority resolver: HALT > dwait > brtaken > jmp > load-use > I-miss.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        ctrl      = CTRL_RUN;
        redirect  = 1'b0;
        if ((state == HALT) || memHALT) begin
            // Let the halting instruction retire once, then freeze forever.
            ctrl         = CTRL_FREEZE;
            ctrl.memwbEn = (state != HALT);
            nextState    = HALT;
        end else if (dwait) begin
            // Any pending branch stays parked in the frozen EX/MEM.
            ctrl      = CTRL_FREEZE;
            nextState = DWAIT;
        end else begin
            nextState = RUN;
            if (brtaken) begin
                ctrl            = CTRL_BRANCH;
                ctrl.exmemFlush = (BR_FLUSH == 2);
                redirect        = 1'b1;
            end else if (jmp) begin
                ctrl     = CTRL_JUMP;
                redirect = 1'b1;
            end else if (loadUse || !ihit) begin
                ctrl = CTRL_BUBBLE;
            end
        end
    end

    // Hazard FSM state; HALT is only left through reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Outputs are forced low while reset is held, whatever the decode says.
    assign pc_en       = nRST & ctrl.pcEn;
    assign ifid_en     = nRST & ctrl.ifidEn;
    assign ifid_flush  = nRST & ctrl.ifidFlush;
    assign idW         = nRST & ctrl.idW;
    assign idRST       = nRST & ctrl.idRst;
    assign exmem_en    = nRST & ctrl.exmemEn;
    assign exmem_flush = nRST & ctrl.exmemFlush;
    assign memwb_en    = nRST & ctrl.memwbEn;
    assign halted      = (state == HALT);

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (~pc_en & ~halted),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (redirect),
        .clear (1'b0),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed vectors and
// queues hand-computed expectations; a monitor pops and compares each
// cycle. A second narrow instance (2-bit counters, single-stage branch
// flush) runs on the same stimulus to exercise saturation and BR_FLUSH=1.
module tb_hazard_ctrl;

    logic CLK = 1'b0;
    logic nRST;
    logic ihit, dhit, memREN, memWEN, exDRE, iduses2, brtaken, jmp, memHALT;
    logic [4:0] exrt, idrsel1, idrsel2;

    logic pc_en, ifid_en, ifid_flush, idW, idRST, exmem_en, exmem_flush, memwb_en, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic s_pc_en, s_ifid_en, s_ifid_flush, s_idW, s_idRST, s_exmem_en, s_exmem_flush, s_memwb_en, s_halted;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memREN(memREN), .memWEN(memWEN),
        .exDRE(exDRE), .exrt(exrt), .idrsel1(idrsel1), .idrsel2(idrsel2), .iduses2(iduses2),
        .brtaken(brtaken), .jmp(jmp), .memHALT(memHALT),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idW(idW), .idRST(idRST),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2), .BR_FLUSH(1)) dutSmall (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memREN(memREN), .memWEN(memWEN),
        .exDRE(exDRE), .exrt(exrt), .idrsel1(idrsel1), .idrsel2(idrsel2), .iduses2(iduses2),
        .brtaken(brtaken), .jmp(jmp), .memHALT(memHALT),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idW(s_idW), .idRST(s_idRST),
        .exmem_en(s_exmem_en), .exmem_flush(s_exmem_flush), .memwb_en(s_memwb_en), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Control word order: {pc_en, ifid_en, ifid_flush, idW, idRST, exmem_en, exmem_flush, memwb_en}
    localparam logic [7:0] C_ALL   = 8'b1101_0101;
    localparam logic [7:0] C_ZERO  = 8'b0000_0000;
    localparam logic [7:0] C_BUB   = 8'b0001_1101;
    localparam logic [7:0] C_BR    = 8'b1111_1111;
    localparam logic [7:0] C_JMP   = 8'b1111_0101;
    localparam logic [7:0] C_DRAIN = 8'b0000_0001;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic        hlt;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t expQ[$];

    // Apply one vector just after the rising edge and queue what should be seen.
    task automatic drive(
        input string name, input logic rn,
        input logic ih, input logic dh, input logic ren, input logic wen,
        input logic exd, input logic [4:0] ert, input logic [4:0] r1, input logic [4:0] r2, input logic u2,
        input logic br, input logic jp, input logic mh,
        input logic [7:0] ctl, input logic eh, input logic [31:0] esc, input logic [31:0] efc
    );
        exp_t e;
        @(posedge CLK);
        #1;
        nRST = rn; ihit = ih; dhit = dh; memREN = ren; memWEN = wen;
        exDRE = exd; exrt = ert; idrsel1 = r1; idrsel2 = r2; iduses2 = u2;
        brtaken = br; jmp = jp; memHALT = mh;
        e.name = name; e.ctl = ctl; e.hlt = eh; e.sc = esc; e.fc = efc;
        expQ.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    exp_t cur;
    logic [7:0] sExpCtl;
    logic [1:0] sExpSc, sExpFc;
    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            total++;
            if ({pc_en, ifid_en, ifid_flush, idW, idRST, exmem_en, exmem_flush, memwb_en} !== cur.ctl ||
                halted !== cur.hlt || stall_cnt !== cur.sc || flush_cnt !== cur.fc) begin
                bad++;
                $display("FAIL %s: got ctl=%b halted=%b stall=%0d flush=%0d, want ctl=%b halted=%b stall=%0d flush=%0d",
                         cur.name, {pc_en, ifid_en, ifid_flush, idW, idRST, exmem_en, exmem_flush, memwb_en},
                         halted, stall_cnt, flush_cnt, cur.ctl, cur.hlt, cur.sc, cur.fc);
            end
            // Narrow instance: no EX/MEM squash on branches, counters pinned at 3.
            sExpCtl = cur.ctl & 8'b1111_1101;
            sExpSc  = (cur.sc > 32'd3) ? 2'd3 : cur.sc[1:0];
            sExpFc  = (cur.fc > 32'd3) ? 2'd3 : cur.fc[1:0];
            total++;
            if ({s_pc_en, s_ifid_en, s_ifid_flush, s_idW, s_idRST, s_exmem_en, s_exmem_flush, s_memwb_en} !== sExpCtl ||
                s_halted !== cur.hlt || s_stall_cnt !== sExpSc || s_flush_cnt !== sExpFc) begin
                bad++;
                $display("FAIL %s_small: got ctl=%b halted=%b stall=%0d flush=%0d, want ctl=%b halted=%b stall=%0d flush=%0d",
                         cur.name, {s_pc_en, s_ifid_en, s_ifid_flush, s_idW, s_idRST, s_exmem_en, s_exmem_flush, s_memwb_en},
                         s_halted, s_stall_cnt, s_flush_cnt, sExpCtl, cur.hlt, sExpSc, sExpFc);
            end
        end
    end

    initial begin
        nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; memREN = 1'b0; memWEN = 1'b0;
        exDRE = 1'b0; exrt = 5'd0; idrsel1 = 5'd0; idrsel2 = 5'd0; iduses2 = 1'b0;
        brtaken = 1'b0; jmp = 1'b0; memHALT = 1'b0;

        //     name           rn ih dh rn wn xd ert r1 r2 u2 br jp mh  ctl      h  sc  fc
        drive("reset",        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO,  0, 0,  0);
        drive("idle",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL,   0, 0,  0);
        // load-use stall lasts one cycle
        drive("lu_rs",        1, 1, 0, 0, 0, 1, 5, 5, 7, 1, 0, 0, 0, C_BUB,   0, 0,  0);
        drive("lu_done",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL,   0, 1,  0);
        drive("lu_rt",        1, 1, 0, 0, 0, 1, 7, 3, 7, 1, 0, 0, 0, C_BUB,   0, 1,  0);
        drive("lu_rt_unused", 1, 1, 0, 0, 0, 1, 7, 3, 7, 0, 0, 0, 0, C_ALL,   0, 2,  0);
        drive("lu_r0",        1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, C_ALL,   0, 2,  0);
        drive("imiss",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_BUB,   0, 2,  0);
        // three-cycle data wait, then release
        drive("dwait1",       1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO,  0, 3,  0);
        drive("dwait2",       1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO,  0, 4,  0);
        drive("dwait3",       1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO,  0, 5,  0);
        drive("dwait_rel",    1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL,   0, 6,  0);
        // branch parked under a store wait, acted on at release
        drive("br_in_wait",   1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, C_ZERO,  0, 6,  0);
        drive("br_release",   1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,    0, 7,  0);
        drive("br_over_lu",   1, 1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 0, 0, C_BR,    0, 7,  1);
        drive("jmp",          1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_JMP,   0, 7,  2);
        drive("jmp_over_lu",  1, 1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 1, 0, C_JMP,   0, 7,  3);
        drive("br_over_jmp",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_BR,    0, 7,  4);
        drive("idle2",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL,   0, 7,  5);
        // reset in the middle of a data wait
        drive("dwait_pre",    1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO,  0, 7,  5);
        drive("rst_mid",      0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO,  0, 0,  0);
        drive("rst_release",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALL,   0, 0,  0);
        // halt beats a concurrent data wait, drains once, then sticks
        drive("halt_drain",   1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_DRAIN, 0, 0,  0);
        drive("halted_jmp",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ZERO,  1, 1,  0);
        drive("halted_br",    1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_ZERO,  1, 1,  0);
        drive("halted_idle",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO,  1, 1,  0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge CLK);
        @(posedge CLK);
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard control for the 5-stage pipeline.
- Produces the write-enable (idW) and flush (idRST) controls of the ID/EX register, plus the PC, IF/ID, EX/MEM and MEM/WB enables and flushes.
- Detects load-use hazards, branch/jump redirects, data-memory wait and halt.
- Sits between the stage registers and the cache hit signals; keeps stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters.
- BR_FLUSH, 2, number of younger stages squashed on a MEM-resolved branch (1 or 2 only).

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- memREN  in  1  EX/MEM holds a load
- memWEN  in  1  EX/MEM holds a store
- exDRE  in  1  ID/EX holds a load (excuDRE)
- exrt  in  5  destination register of the ID/EX load
- idrsel1  in  5  rs of the instruction in decode
- idrsel2  in  5  rt of the instruction in decode
- iduses2  in  1  decode instruction reads rt (R-type, branch, store)
- brtaken  in  1  branch taken, resolved in MEM
- jmp  in  1  J/JAL/JR resolved in EX
- memHALT  in  1  halt reached MEM
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID clear
- idW  out  1  ID/EX write enable
- idRST  out  1  ID/EX clear (bubble insert)
- exmem_en  out  1  EX/MEM write enable
- exmem_flush  out  1  EX/MEM clear
- memwb_en  out  1  MEM/WB write enable
- halted  out  1  sticky halt
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
- flush_cnt  out  CNT_W  redirect events

Behaviour:
- Clock and reset: single clock CLK; nRST is asynchronous and active-low.
- Reset values: state=RUN, halted=0, counters=0. All enables evaluate combinationally from state and inputs; with nRST low, every enable and flush output is 0.
- dwait = (memREN|memWEN) & ~dhit.
- lu = exDRE & (exrt!=0) & ((exrt==idrsel1) | (iduses2 & exrt==idrsel2)).
- States: RUN, DWAIT, HALT.
- Priority each cycle: HALT > dwait > brtaken > jmp > lu > ~ihit.
- HALT state, or memHALT in any state:
  - All enables 0 except memwb_en=1 for one cycle (drains the halt).
  - halted=1 from the next edge; HALT is left only by reset.
- dwait:
  - All enables 0 and all flushes 0; the whole pipe freezes.
  - Go to DWAIT; return to RUN in the cycle dhit=1. In that cycle the normal RUN rules apply.
  - brtaken arriving with dwait is held in the frozen EX/MEM and acted on at release.
- brtaken, no dwait:
  - pc_en=1 (target load), ifid_flush=1, idRST=1.
  - If BR_FLUSH==2, also exmem_flush=1.
  - flush_cnt++.
- jmp, no brtaken:
  - pc_en=1, ifid_flush=1, idW=1, flush_cnt++.
- lu:
  - pc_en=0 and ifid_en=0; ID/EX receives a bubble (idRST=1, idW=1).
  - EX/MEM and MEM/WB advance.
  - The stall lasts exactly one cycle, because the load leaves ID/EX.
- ~ihit:
  - pc_en=0, ifid_en=0, idRST=1 (bubble).
  - Later stages advance so a pending load can retire.
- Otherwise: all enables 1, flushes 0.
- Flush dominance: a flush has priority over a same-stage enable. When flush=1 the register loads zero.
- Counters:
  - stall_cnt increments on every cycle with pc_en=0 & ~halted.
  - Both counters saturate at all-ones and do not wrap.
- Reset mid-stall: asynchronous clear to RUN; no stale bubble state survives.

Decomposition:
- Add hz_state_t (RUN, DWAIT, HALT) to cpu_types_pkg.
- A saturating counter sub-module sat_counter (parameter W, inputs inc and clear) is instantiated twice.
- The priority resolver stays in a single always_comb.

Test Plan:
1. Load r5, then `add r6,r5,r7` in decode; exDRE=1, exrt=5, idrsel1=5 -> one cycle with pc_en=0, ifid_en=0, idRST=1. Next cycle all enables 1; stall_cnt=1.
2. memREN=1, dhit=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, RUN on the 4th; stall_cnt=3.
3. brtaken=1 with BR_FLUSH=2 -> pc_en=1, ifid_flush=1, idRST=1, exmem_flush=1; flush_cnt=1. Set brtaken and lu together -> the branch outcome wins and idW is not held low.
4. memHALT=1 -> memwb_en=1 for one cycle, then all enables 0. halted=1 is sticky through a later ihit=1 and jmp=1.
5. Assert nRST=0 mid-DWAIT -> outputs 0 immediately and counters 0. After release, state=RUN with enables 1 when ihit=1.
6. Preload stall_cnt to all-ones via force, then stall -> value remains all-ones.
